tmr_resync_ctrl: RTL and testbench

//  Supervises a bank of NVOTERS triplicated-logic voters. Collects each voter's err output and

---
 rtl/tmr_resync_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_tmr_resync_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_resync_ctrl.sv
// tmr_resync_ctrl: supervisor for a bank of TMR voters. Collects voter err
// levels into sticky flags and a saturating counter, runs a
// settle -> resync -> cooldown sequence on disagreement and latches a fault
// after repeated failed attempts.
// Optional feature: define TMR_FIRST_ERR_EN to add first_err_valid/first_err_idx,
// which record the lowest-index voter of the first error after reset or clear.
module tmr_resync_ctrl #(
  parameter int NVOTERS         = 8,
  parameter int CNT_W           = 16,
  parameter int SETTLE_CYCLES   = 2,
  parameter int RESYNC_CYCLES   = 4,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int FAULT_LIMIT     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NVOTERS-1:0] err_i,
  input  logic [NVOTERS-1:0] err_mask,
  input  logic               clear,
  output logic               resync,
  output logic [NVOTERS-1:0] resync_sel,
  output logic               busy,
  output logic               fault,
  output logic [NVOTERS-1:0] err_sticky,
  output logic [CNT_W-1:0]   err_count
`ifdef TMR_FIRST_ERR_EN
  ,
  output logic                       first_err_valid,
  output logic [$clog2(NVOTERS)-1:0] first_err_idx
`endif
);

  // One phase counter is shared by SETTLE, RESYNC and COOLDOWN, so it is
  // sized for the longest of the three phases.
  localparam int MAXC = (SETTLE_CYCLES > RESYNC_CYCLES) ?
                        ((SETTLE_CYCLES > COOLDOWN_CYCLES) ? SETTLE_CYCLES : COOLDOWN_CYCLES) :
                        ((RESYNC_CYCLES > COOLDOWN_CYCLES) ? RESYNC_CYCLES : COOLDOWN_CYCLES);
  localparam int CW = $clog2(MAXC + 1);
  localparam int RW = $clog2(FAULT_LIMIT + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] RESYNC_LAST = CW'(RESYNC_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LAST   = CW'(COOLDOWN_CYCLES - 1);
  // retry already holds FAULT_LIMIT-1 failures -> this one is the last allowed
  localparam logic [RW-1:0] RETRY_LAST  = RW'(FAULT_LIMIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESYNC,
    ST_COOLDOWN,
    ST_FAULT
  } state_t;

  // Saturating increment of the error counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    if (inc && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  // ---- stage p0: masked sample of the voter error levels ----
  logic [NVOTERS-1:0] masked_p0;
  logic               any_err_p0;

  assign masked_p0  = err_i & ~err_mask;
  assign any_err_p0 = |masked_p0;

  // ---- stage p1: registered sequencer state and outputs ----
  state_t        state_p1, state_d;
  logic [CW-1:0] cnt_p1, cnt_d;
  logic [RW-1:0] retry_p1, retry_d;

  logic [NVOTERS-1:0] sel_d;
  logic               resync_d;
  logic               busy_d;
  logic               fault_d;
  logic [NVOTERS-1:0] sticky_d;
  logic [CNT_W-1:0]   count_d;

  // Sequencer next-state, phase counting and resync selection.
  always_comb begin
    state_d = state_p1;
    cnt_d   = cnt_p1;
    retry_d = retry_p1;
    sel_d   = resync_sel;
    case (state_p1)
      ST_IDLE: begin
        cnt_d = '0;
        if (any_err_p0) begin
          state_d = ST_SETTLE;
          sel_d   = masked_p0;
        end
      end
      ST_SETTLE: begin
        // keep collecting late-arriving disagreements until the window closes
        sel_d = resync_sel | masked_p0;
        if (cnt_p1 == SETTLE_LAST) begin
          state_d = ST_RESYNC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_p1 + CW'(1);
        end
      end
      ST_RESYNC: begin
        // selection frozen; errors here only affect the stats
        if (cnt_p1 == RESYNC_LAST) begin
          state_d = ST_COOLDOWN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_p1 + CW'(1);
        end
      end
      ST_COOLDOWN: begin
        if (any_err_p0) begin
          cnt_d = '0;
          if (retry_p1 == RETRY_LAST) begin
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_p1 + RW'(1);
            state_d = ST_SETTLE;
            sel_d   = masked_p0;
          end
        end else if (cnt_p1 == COOL_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          retry_d = '0;
          sel_d   = '0;
        end else begin
          cnt_d = cnt_p1 + CW'(1);
        end
      end
      ST_FAULT: begin
        // resync_sel keeps the last attempt's selection for diagnosis;
        // IDLE only starts sampling on the cycle after the clear
        if (clear) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          retry_d = '0;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        retry_d = '0;
        sel_d   = '0;
      end
    endcase

    resync_d = (state_d == ST_RESYNC);
    fault_d  = (state_d == ST_FAULT);
    busy_d   = (state_d == ST_SETTLE) || (state_d == ST_RESYNC) ||
               (state_d == ST_COOLDOWN);
  end

  // Error statistics; a clear restarts them from this cycle's sample so no
  // error coincident with the clear is lost.
  always_comb begin
    sticky_d = err_sticky | masked_p0;
    count_d  = sat_inc(err_count, any_err_p0);
    if (clear) begin
      sticky_d = masked_p0;
      count_d  = CNT_W'(any_err_p0);
    end
  end

  // State and output registers; reset clears everything and abandons any sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1   <= ST_IDLE;
      cnt_p1     <= '0;
      retry_p1   <= '0;
      resync     <= 1'b0;
      resync_sel <= '0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      err_sticky <= '0;
      err_count  <= '0;
    end else begin
      state_p1   <= state_d;
      cnt_p1     <= cnt_d;
      retry_p1   <= retry_d;
      resync     <= resync_d;
      resync_sel <= sel_d;
      busy       <= busy_d;
      fault      <= fault_d;
      err_sticky <= sticky_d;
      err_count  <= count_d;
    end
  end

`ifdef TMR_FIRST_ERR_EN
  localparam int IDX_W = $clog2(NVOTERS);

  // Lowest set bit index; 0 when nothing is set.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NVOTERS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NVOTERS - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Capture the first error after reset/clear; clear re-arms and may capture at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else if (clear) begin
      first_err_valid <= any_err_p0;
      first_err_idx   <= lowest_idx(masked_p0);
    end else if (!first_err_valid && any_err_p0) begin
      first_err_valid <= 1'b1;
      first_err_idx   <= lowest_idx(masked_p0);
    end
  end
`endif

endmodule

// File: tb/tb_tmr_resync_ctrl.sv
// Self-checking bench for tmr_resync_ctrl: a reference model predicts every
// output after each clock; predictions are queued when stimulus is driven and
// compared when the DUT output is sampled. Directed scenarios add explicit
// timing and value checks. Honours TMR_FIRST_ERR_EN like the design.
module tb_tmr_resync_ctrl;

  localparam int NV       = 8;
  localparam int CNT_W    = 4;
  localparam int SETTLE   = 2;
  localparam int RESYNC_N = 4;
  localparam int COOL     = 16;
  localparam int LIMIT    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NV-1:0]    err_i = '0;
  logic [NV-1:0]    err_mask = '0;
  logic             clear = 1'b0;
  logic             resync;
  logic [NV-1:0]    resync_sel;
  logic             busy;
  logic             fault;
  logic [NV-1:0]    err_sticky;
  logic [CNT_W-1:0] err_count;
`ifdef TMR_FIRST_ERR_EN
  logic             first_err_valid;
  logic [2:0]       first_err_idx;
`endif

  tmr_resync_ctrl #(
    .NVOTERS(NV), .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE),
    .RESYNC_CYCLES(RESYNC_N), .COOLDOWN_CYCLES(COOL), .FAULT_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .err_i(err_i), .err_mask(err_mask), .clear(clear),
    .resync(resync), .resync_sel(resync_sel), .busy(busy), .fault(fault),
    .err_sticky(err_sticky), .err_count(err_count)
`ifdef TMR_FIRST_ERR_EN
    , .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]  ctl;   // {resync, busy, fault}
    logic [7:0]  sel;
    logic [7:0]  sticky;
    logic [3:0]  cnt;
    logic        fv;
    logic [2:0]  fidx;
  } exp_t;

  exp_t sbq[$];

  // reference model state: 0 idle, 1 settle, 2 resync, 3 cooldown, 4 fault
  int         m_state = 0;
  int         m_left  = 0;
  int         m_tries = 0;
  logic [7:0] m_sel = '0;
  logic [7:0] m_sticky = '0;
  int         m_cnt = 0;
  logic       m_fv = 1'b0;
  int         m_fidx = 0;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model(input logic r, input logic [7:0] e, input logic [7:0] m, input logic c);
    logic [7:0] mk;
    logic       a;
    mk = e & ~m;
    a  = |mk;
    if (r) begin
      m_state = 0; m_left = 0; m_tries = 0; m_sel = '0;
      m_sticky = '0; m_cnt = 0; m_fv = 1'b0; m_fidx = 0;
      return;
    end
    if (c) begin
      m_sticky = mk;
      m_cnt    = a ? 1 : 0;
      m_fv     = a;
      m_fidx   = lowest(mk);
    end else begin
      m_sticky = m_sticky | mk;
      if (a && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (!m_fv && a) begin
        m_fv   = 1'b1;
        m_fidx = lowest(mk);
      end
    end
    case (m_state)
      0: if (a) begin m_state = 1; m_left = SETTLE; m_sel = mk; end
      1: begin
        m_sel = m_sel | mk;
        m_left--;
        if (m_left == 0) begin m_state = 2; m_left = RESYNC_N; end
      end
      2: begin
        m_left--;
        if (m_left == 0) begin m_state = 3; m_left = COOL; end
      end
      3: begin
        if (a) begin
          m_tries++;
          if (m_tries == LIMIT) m_state = 4;
          else begin m_state = 1; m_left = SETTLE; m_sel = mk; end
        end else begin
          m_left--;
          if (m_left == 0) begin m_state = 0; m_tries = 0; m_sel = '0; end
        end
      end
      default: if (c) begin m_state = 0; m_tries = 0; m_sel = '0; end
    endcase
  endtask

  // Drive one cycle of stimulus, queue the prediction, compare after the edge.
  task automatic step(input logic r, input logic [7:0] e, input logic [7:0] m, input logic c);
    exp_t x;
    @(negedge clk);
    rst = r; err_i = e; err_mask = m; clear = c;
    model(r, e, m, c);
    x.ctl    = {(m_state == 2), (m_state >= 1 && m_state <= 3), (m_state == 4)};
    x.sel    = m_sel;
    x.sticky = m_sticky;
    x.cnt    = 4'(m_cnt);
    x.fv     = m_fv;
    x.fidx   = 3'(m_fidx);
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    check("ctl", 32'({resync, busy, fault}), 32'(x.ctl));
    check("sel", 32'(resync_sel), 32'(x.sel));
    check("sticky", 32'(err_sticky), 32'(x.sticky));
    check("count", 32'(err_count), 32'(x.cnt));
`ifdef TMR_FIRST_ERR_EN
    check("first", 32'({first_err_valid, first_err_idx}), 32'({x.fv, x.fidx}));
`endif
  endtask

  task automatic do_reset();
    step(1'b1, 8'h00, 8'h00, 1'b0);
    step(1'b1, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rs, rs_n, busy_off, rises, k;
    logic [7:0] sel_first, sel_last;
    logic busy_seen, prev_rs;

    // ---- reset state ----
    do_reset();
    check("rst_outs", 32'({resync, busy, fault, resync_sel, err_sticky, err_count}), 32'(0));

    // ---- single-cycle error: timing of busy/resync and stats ----
    first_rs = -1; rs_n = 0; busy_off = -1; sel_first = '0;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, (i == 1) ? 8'h04 : 8'h00, 8'h00, 1'b0);
      if (i == 1) check("t1_busy_rise", 32'(busy), 32'(1));
      if (resync) begin
        if (first_rs < 0) begin first_rs = i; sel_first = resync_sel; end
        rs_n++;
      end
      if (!busy && busy_off < 0) busy_off = i;
    end
    check("t1_rs_first", 32'(first_rs), 32'(3));
    check("t1_rs_len", 32'(rs_n), 32'(4));
    check("t1_rs_sel", 32'(sel_first), 32'(8'h04));
    check("t1_busy_off", 32'(busy_off), 32'(23));
    check("t1_count", 32'(err_count), 32'(1));
    check("t1_sticky", 32'(err_sticky), 32'(8'h04));

    // ---- error on another voter during SETTLE merges into the selection ----
    do_reset();
    sel_first = '0; sel_last = '0; first_rs = -1;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, (i == 1) ? 8'h01 : ((i == 3) ? 8'h80 : 8'h00), 8'h00, 1'b0);
      if (resync) begin
        if (first_rs < 0) begin first_rs = i; sel_first = resync_sel; end
        sel_last = resync_sel;
      end
    end
    check("t2_sel_first", 32'(sel_first), 32'(8'h81));
    check("t2_sel_last", 32'(sel_last), 32'(8'h81));
    check("t2_idle", 32'(busy), 32'(0));

    // ---- persistent error escalates to fault; clear releases it ----
    do_reset();
    rises = 0; prev_rs = 1'b0; k = 0;
    while (!fault && k < 200) begin
      step(1'b0, 8'h02, 8'h00, 1'b0);
      if (resync && !prev_rs) rises++;
      prev_rs = resync;
      k++;
    end
    check("t3_fault", 32'(fault), 32'(1));
    check("t3_busy", 32'(busy), 32'(0));
    check("t3_attempts", 32'(rises), 32'(3));
    step(1'b0, 8'h02, 8'h00, 1'b0);
    check("t3_fault_hold", 32'({fault, resync, resync_sel}), 32'({2'b10, 8'h02}));
    step(1'b0, 8'h02, 8'h00, 1'b1);
    check("t3_clr_fault", 32'({fault, busy}), 32'(0));
    check("t3_clr_count", 32'(err_count), 32'(1));
    check("t3_clr_sticky", 32'(err_sticky), 32'(8'h02));
    step(1'b0, 8'h02, 8'h00, 1'b0);
    check("t3_rearm", 32'(busy), 32'(1));
    for (int i = 0; i < 30; i++) step(1'b0, 8'h00, 8'h00, 1'b0);

    // ---- fully masked voters are invisible ----
    do_reset();
    busy_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'hFF, 8'hFF, 1'b0);
      busy_seen = busy_seen | busy;
    end
    check("t4_busy", 32'(busy_seen), 32'(0));
    check("t4_count", 32'(err_count), 32'(0));
    check("t4_sticky", 32'(err_sticky), 32'(0));

    // ---- counter saturation ----
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b0, 8'h10, 8'h00, 1'b0);
    check("t5_sat", 32'(err_count), 32'(15));

    // ---- reset during RESYNC ----
    do_reset();
    step(1'b0, 8'h10, 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    check("t5_in_resync", 32'(resync), 32'(1));
    step(1'b1, 8'h00, 8'h00, 1'b0);
    check("t5_rst_outs", 32'({resync, busy, fault, resync_sel, err_sticky, err_count}), 32'(0));
    step(1'b0, 8'h00, 8'h00, 1'b0);
    check("t5_no_resume", 32'({resync, busy}), 32'(0));

`ifdef TMR_FIRST_ERR_EN
    // ---- first-error capture ----
    do_reset();
    step(1'b0, 8'h28, 8'h00, 1'b0);
    check("t6_first", 32'({first_err_valid, first_err_idx}), 32'({1'b1, 3'd3}));
    step(1'b0, 8'h01, 8'h00, 1'b0);
    check("t6_hold", 32'({first_err_valid, first_err_idx}), 32'({1'b1, 3'd3}));
    step(1'b0, 8'h40, 8'h00, 1'b1);
    check("t6_recap", 32'({first_err_valid, first_err_idx}), 32'({1'b1, 3'd6}));
    step(1'b0, 8'h00, 8'h00, 1'b1);
    check("t6_clr", 32'(first_err_valid), 32'(0));
`endif

    // ---- random traffic: sparse errors, masks, clears, resets ----
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] e, m;
      logic c, r;
      e = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      c = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 149) == 0);
      step(r, e, m, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
